// File: rtl/crank_gen_pkg.sv
// ----------------------------------------------------------------------------
// crank_gen_pkg
// Shared types and constants for the synthetic crank trigger-wheel generator.
//   crank_gen_state_t : generator FSM states (IDLE, TOOTH_HI, TOOTH_LO, GAP)
//   PERIOD_MIN        : smallest usable slot period; shorter requests are
//                       stretched to this so every slot has a high and a low
//   DEFAULT_WIDTH     : default width of the period / slot counter
//   DEFAULT_TW        : default width of tooth counts and slot index
// ----------------------------------------------------------------------------
package crank_gen_pkg;

    localparam int DEFAULT_WIDTH = 24;
    localparam int DEFAULT_TW    = 8;
    localparam int PERIOD_MIN    = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TOOTH_HI = 2'd1,
        TOOTH_LO = 2'd2,
        GAP      = 2'd3
    } crank_gen_state_t;

endpackage

// File: rtl/crank_slot_timer.sv
// ----------------------------------------------------------------------------
// crank_slot_timer
// Times one wheel slot. On load it captures the slot period (stretched to
// PERIOD_MIN) and restarts its cycle counter at 0; while running it counts
// 0..P-1 and flags the last high cycle and the last cycle of the slot.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : return the counter to 0 (generator stopped)
//   load        : first cycle of a new slot follows; capture period
//   run         : generator active, advance the counter
//   period      : requested slot period in clk cycles
//   half_hit    : counter is on the last cycle of the high phase, (P>>1)-1
//   end_hit     : counter is on the last cycle of the slot, P-1
// ----------------------------------------------------------------------------
module crank_slot_timer
    import crank_gen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             run,
    input  logic [WIDTH-1:0] period,
    output logic             half_hit,
    output logic             end_hit
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] p_reg;
    logic [WIDTH-1:0] p_eff;

    // Periods of 0 or 1 cannot produce a high and a low phase, so they run
    // as the minimum period instead.
    always_comb begin
        p_eff = period;
        if (period < WIDTH'(PERIOD_MIN)) begin
            p_eff = WIDTH'(PERIOD_MIN);
        end
    end

    // The period is only captured at a slot boundary, so a write to period
    // in the middle of a slot never stretches or shortens that slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            p_reg <= WIDTH'(PERIOD_MIN);
        end else if (clear) begin
            cnt   <= '0;
        end else if (load) begin
            cnt   <= '0;
            p_reg <= p_eff;
        end else if (run) begin
            cnt   <= cnt + WIDTH'(1);
        end
    end

    assign half_hit = (cnt == ((p_reg >> 1) - WIDTH'(1)));
    assign end_hit  = (cnt == (p_reg - WIDTH'(1)));

endmodule

// File: rtl/crank_wheel_gen.sv
// ----------------------------------------------------------------------------
// crank_wheel_gen
// Synthetic crank trigger-wheel generator (e.g. 60-2). Emits a square wave of
// teeth_total slots per revolution; the last teeth_missing slots stay low to
// form the reference gap. Drives the capture input of the angle generator for
// self-test and bench stimulus.
// Optional feature macro: CRANK_GEN_CAM_EN adds a cam phase output that
// toggles at every revolution start; without it, cam is tied to 0.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   en             : 1 = run, 0 = stop and return to the reset state
//   period         : slot period in clk cycles (latched per slot, min 2)
//   teeth_total    : slots per revolution (latched at slot 0 start)
//   teeth_missing  : gap slots at the end of the revolution (latched likewise)
//   tooth          : generated wheel signal
//   tooth_num      : current slot index 0..teeth_total-1
//   rev            : one-clk pulse when slot 0 starts
//   cfg_err        : tooth configuration invalid, generator held idle
//   cam            : cam phase (two revolutions per period)
// ----------------------------------------------------------------------------
module crank_wheel_gen
    import crank_gen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int TW    = DEFAULT_TW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] period,
    input  logic [TW-1:0]    teeth_total,
    input  logic [TW-1:0]    teeth_missing,
    output logic             tooth,
    output logic [TW-1:0]    tooth_num,
    output logic             rev,
    output logic             cfg_err,
    output logic             cam
);

    crank_gen_state_t state;
    logic [TW-1:0]    tt_lat;
    logic [TW-1:0]    tm_lat;
    logic [TW-1:0]    next_slot;
    logic [TW-1:0]    gap_start;
    logic             cfg_ok;
    logic             slot_end;
    logic             start_rev;
    logic             load;
    logic             half_hit;
    logic             end_hit;

    // A wheel needs at least three slots and must keep at least three real
    // teeth; the range check on teeth_missing is only meaningful once
    // teeth_total itself is large enough.
    always_comb begin
        cfg_ok = 1'b0;
        if (teeth_total >= TW'(3)) begin
            cfg_ok = (teeth_missing <= (teeth_total - TW'(3)));
        end
    end

    // Slot sequencing uses the configuration latched at the start of the
    // revolution so a mid-revolution change cannot break the current lap.
    // start_rev covers both a fresh start from IDLE and the wrap back to
    // slot 0, which is where the configuration is sampled again.
    always_comb begin
        next_slot = tooth_num + TW'(1);
        if (tooth_num == (tt_lat - TW'(1))) begin
            next_slot = '0;
        end
        gap_start = tt_lat - tm_lat;
        slot_end  = ((state == TOOTH_LO) || (state == GAP)) && end_hit;
        start_rev = en && cfg_ok &&
                    ((state == IDLE) || (slot_end && (next_slot == '0)));
        load      = en && (((state == IDLE) && cfg_ok) || slot_end);
    end

    crank_slot_timer #(
        .WIDTH (WIDTH)
    ) u_slot_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!en),
        .load     (load),
        .run      (state != IDLE),
        .period   (period),
        .half_hit (half_hit),
        .end_hit  (end_hit)
    );

    // Generator FSM. All outputs are registered here and change on the clk
    // that enters the new phase, so tooth, tooth_num and rev move together
    // at a slot boundary. Dropping en parks everything except cfg_err, which
    // keeps reporting the last configuration verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tooth     <= 1'b0;
            tooth_num <= '0;
            rev       <= 1'b0;
            cfg_err   <= 1'b0;
            tt_lat    <= '0;
            tm_lat    <= '0;
        end else if (!en) begin
            state     <= IDLE;
            tooth     <= 1'b0;
            tooth_num <= '0;
            rev       <= 1'b0;
        end else begin
            rev <= 1'b0;
            if (start_rev) begin
                state     <= TOOTH_HI;
                tooth     <= 1'b1;
                tooth_num <= '0;
                rev       <= 1'b1;
                cfg_err   <= 1'b0;
                tt_lat    <= teeth_total;
                tm_lat    <= teeth_missing;
            end else begin
                case (state)
                    IDLE: begin
                        cfg_err <= 1'b1;
                    end
                    TOOTH_HI: begin
                        if (half_hit) begin
                            state <= TOOTH_LO;
                            tooth <= 1'b0;
                        end
                    end
                    TOOTH_LO, GAP: begin
                        if (end_hit) begin
                            if (next_slot == '0) begin
                                state     <= IDLE;
                                tooth     <= 1'b0;
                                tooth_num <= '0;
                                cfg_err   <= 1'b1;
                            end else if (next_slot >= gap_start) begin
                                state     <= GAP;
                                tooth     <= 1'b0;
                                tooth_num <= next_slot;
                            end else begin
                                state     <= TOOTH_HI;
                                tooth     <= 1'b1;
                                tooth_num <= next_slot;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef CRANK_GEN_CAM_EN
    // Cam phase flips once per revolution, giving one cam cycle per 720 deg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam <= 1'b0;
        end else if (!en) begin
            cam <= 1'b0;
        end else if (start_rev) begin
            cam <= ~cam;
        end
    end
`else
    assign cam = 1'b0;
`endif

endmodule

// File: tb/tb_crank_wheel_gen.sv
// ----------------------------------------------------------------------------
// tb_crank_wheel_gen
// Self-checking bench for crank_wheel_gen. A wheel model built from slot
// position arithmetic predicts every output each cycle; directed scenarios
// add hand-computed timing expectations (spans, intervals, reset values).
// Honours CRANK_GEN_CAM_EN for the cam expectations.
// ----------------------------------------------------------------------------
module tb_crank_wheel_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [23:0] period = 24'd10;
    logic [7:0]  teeth_total = 8'd60;
    logic [7:0]  teeth_missing = 8'd2;
    logic        tooth;
    logic [7:0]  tooth_num;
    logic        rev;
    logic        cfg_err;
    logic        cam;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;
    int c = 0;
    int hi_len = 0;
    int lo_len = 0;

    // Wheel model state: running flag, slot index, position inside the
    // slot, latched period and configuration, plus the output flags.
    bit m_run = 1'b0;
    int m_slot = 0;
    int m_pos = 0;
    int m_p = 2;
    int m_tt = 0;
    int m_tm = 0;
    bit m_err = 1'b0;
    bit m_cam = 1'b0;
    bit m_rev = 1'b0;

    crank_wheel_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .period        (period),
        .teeth_total   (teeth_total),
        .teeth_missing (teeth_missing),
        .tooth         (tooth),
        .tooth_num     (tooth_num),
        .rev           (rev),
        .cfg_err       (cfg_err),
        .cam           (cam)
    );

    // 10 time-unit clock; inputs are driven on the falling edge.
    always #5 clk = ~clk;

    function automatic int effPeriod(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    function automatic bit cfgValid(input int tt, input int tm);
        return (tt >= 3) && (tm <= tt - 3);
    endfunction

    // Beginning of a revolution: either start slot 0 with a fresh
    // configuration or fall back to idle with the error flag raised.
    task automatic modelStartRev();
        m_slot = 0;
        m_pos  = 0;
        if (cfgValid(int'(teeth_total), int'(teeth_missing))) begin
            m_run = 1'b1;
            m_tt  = int'(teeth_total);
            m_tm  = int'(teeth_missing);
            m_p   = effPeriod(int'(period));
            m_rev = 1'b1;
            m_err = 1'b0;
            m_cam = ~m_cam;
        end else begin
            m_run = 1'b0;
            m_err = 1'b1;
        end
    endtask

    // Model advance: one clk moves the position inside the slot; reaching
    // the latched period starts the next slot, wrapping to slot 0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0; m_slot = 0; m_pos = 0; m_p = 2;
            m_err = 1'b0; m_cam = 1'b0; m_rev = 1'b0;
        end else if (!en) begin
            m_run = 1'b0; m_slot = 0; m_pos = 0;
            m_cam = 1'b0; m_rev = 1'b0;
        end else if (!m_run) begin
            m_rev = 1'b0;
            modelStartRev();
        end else begin
            m_rev = 1'b0;
            m_pos = m_pos + 1;
            if (m_pos == m_p) begin
                m_slot = m_slot + 1;
                m_pos  = 0;
                m_p    = effPeriod(int'(period));
                if (m_slot == m_tt) begin
                    modelStartRev();
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        bit       e_tooth;
        bit [7:0] e_num;
        bit       e_cam;
        if (chk_on) begin
            e_tooth = m_run && (m_slot < m_tt - m_tm) && (m_pos < m_p / 2);
            e_num   = m_run ? 8'(m_slot) : 8'd0;
`ifdef CRANK_GEN_CAM_EN
            e_cam   = m_cam;
`else
            e_cam   = 1'b0;
`endif
            checks++;
            if (tooth !== e_tooth || tooth_num !== e_num || rev !== m_rev ||
                cfg_err !== m_err || cam !== e_cam) begin
                errors++;
                $display("[TB] FAIL model_cycle t=%0t got tooth=%0b num=%0d rev=%0b err=%0b cam=%0b want tooth=%0b num=%0d rev=%0b err=%0b cam=%0b",
                         $time, tooth, tooth_num, rev, cfg_err, cam,
                         e_tooth, e_num, m_rev, m_err, e_cam);
            end
        end
    end

    task automatic applyStimulus(input bit e, input int p, input int tt, input int tm);
        en            = e;
        period        = 24'(p);
        teeth_total   = 8'(tt);
        teeth_missing = 8'(tm);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d want %0d", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name, input int cycles);
        checks++;
        errors++;
        $display("[TB] FAIL %s timeout after %0d cycles", name, cycles);
    endtask

    // Bounded waits, each returning the number of falling edges consumed.
    task automatic waitRev(input int limit, output int cycles);
        cycles = 0;
        do begin @(negedge clk); cycles++; end while (rev !== 1'b1 && cycles < limit);
        if (rev !== 1'b1) timeoutFail("wait_rev", cycles);
    endtask

    task automatic waitTooth(input bit level, input int limit, output int cycles);
        cycles = 0;
        do begin @(negedge clk); cycles++; end while (tooth !== level && cycles < limit);
        if (tooth !== level) timeoutFail("wait_tooth", cycles);
    endtask

    task automatic waitSlot(input int num, input int limit, output int cycles);
        cycles = 0;
        do begin @(negedge clk); cycles++; end while (tooth_num !== 8'(num) && cycles < limit);
        if (tooth_num !== 8'(num)) timeoutFail("wait_slot", cycles);
    endtask

    initial begin
        // Reset state
        applyStimulus(0, 10, 60, 2);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        checkOutput("reset_tooth", tooth, 0);
        checkOutput("reset_tooth_num", tooth_num, 0);
        checkOutput("reset_rev", rev, 0);
        checkOutput("reset_cfg_err", cfg_err, 0);
        checkOutput("reset_cam", cam, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 60-2 wheel, period 10
        applyStimulus(1, 10, 60, 2);
        @(negedge clk);
        checkOutput("start_tooth", tooth, 1);
        checkOutput("start_rev", rev, 1);
        checkOutput("start_tooth_num", tooth_num, 0);
`ifdef CRANK_GEN_CAM_EN
        checkOutput("start_cam", cam, 1);
`endif
        waitRev(700, c);
        checkOutput("rev_interval", c, 600);
`ifdef CRANK_GEN_CAM_EN
        checkOutput("cam_second_rev", cam, 0);
`endif
        waitTooth(0, 20, c);
        checkOutput("slot0_high", c, 5);
        waitTooth(1, 20, c);
        checkOutput("slot0_low", c, 5);
        waitSlot(57, 700, c);
        waitTooth(0, 20, hi_len);
        checkOutput("slot57_high", hi_len, 5);
        waitTooth(1, 50, lo_len);
        checkOutput("gap_low_span", lo_len, 25);
        checkOutput("gap_rise_to_rise", hi_len + lo_len, 30);
        checkOutput("gap_wrap_slot", tooth_num, 0);
        checkOutput("gap_wrap_rev", rev, 1);

        // Period change in the middle of slot 7
        waitSlot(7, 200, c);
        repeat (3) @(negedge clk);
        applyStimulus(1, 20, 60, 2);
        waitSlot(8, 50, c);
        checkOutput("slot7_rest_len", c, 7);
        waitTooth(0, 50, c);
        checkOutput("slot8_high", c, 10);
        waitSlot(9, 50, c);
        checkOutput("slot8_low", c, 10);
        applyStimulus(1, 10, 60, 2);

        // Invalid configuration holds the generator idle
        applyStimulus(0, 10, 60, 2);
        @(negedge clk);
        checkOutput("disable_tooth", tooth, 0);
        checkOutput("disable_tooth_num", tooth_num, 0);
        applyStimulus(1, 10, 60, 58);
        @(negedge clk);
        checkOutput("cfg_err_set", cfg_err, 1);
        repeat (20) @(negedge clk);
        checkOutput("cfg_err_hold", cfg_err, 1);
        checkOutput("cfg_err_tooth", tooth, 0);
        applyStimulus(1, 10, 60, 2);
        @(negedge clk);
        checkOutput("cfg_err_clear", cfg_err, 0);
        checkOutput("cfg_ok_tooth", tooth, 1);
        checkOutput("cfg_ok_rev", rev, 1);

        // Asynchronous reset in the middle of slot 30
        waitSlot(30, 400, c);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_tooth", tooth, 0);
        checkOutput("async_reset_tooth_num", tooth_num, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_restart_tooth", tooth, 1);
        checkOutput("reset_restart_rev", rev, 1);

        // Stop during the gap, then restart
        waitSlot(58, 700, c);
        repeat (3) @(negedge clk);
        applyStimulus(0, 10, 60, 2);
        @(negedge clk);
        checkOutput("gap_stop_tooth_num", tooth_num, 0);
        applyStimulus(1, 10, 60, 2);
        @(negedge clk);
        checkOutput("gap_restart_rev", rev, 1);
        checkOutput("gap_restart_tooth", tooth, 1);
        waitTooth(0, 20, c);
        waitSlot(1, 20, c);
        checkOutput("restart_slot1_delay", c, 5);
        checkOutput("restart_no_gap", tooth, 1);

        // Short 6-1 wheel, period 4, then period 1 (runs as 2)
        applyStimulus(0, 4, 6, 1);
        @(negedge clk);
        applyStimulus(1, 4, 6, 1);
        @(negedge clk);
        checkOutput("short_start_rev", rev, 1);
        waitRev(50, c);
        checkOutput("short_rev_interval", c, 24);
`ifdef CRANK_GEN_CAM_EN
        checkOutput("cam_after_24", cam, 0);
`endif
        waitRev(50, c);
        checkOutput("short_rev_interval2", c, 24);
`ifdef CRANK_GEN_CAM_EN
        checkOutput("cam_after_48", cam, 1);
`endif
        applyStimulus(1, 1, 6, 1);
        waitRev(50, c);
        checkOutput("period1_rev_interval", c, 14);
        waitTooth(0, 5, c);
        checkOutput("period1_high", c, 1);
        waitTooth(1, 5, c);
        checkOutput("period1_low", c, 1);
        checkOutput("period1_slot1", tooth_num, 1);

        applyStimulus(0, 10, 60, 2);
        repeat (2) @(negedge clk);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
